// File: rtl/pb_rom_feeder_if.sv
// Bus bundle between pb_rom_feeder, its synchronous ROM and the downstream RAM loader.
//   master (feeder side): drives rom_en, rom_addr, data_out, ROM_RDY, busy and done;
//                         receives rom_dout.
//   slave  (ROM/loader side): the mirror image.
// Signals:
//   rom_en    ROM read enable
//   rom_addr  ROM read address (ADDR_W bits)
//   rom_dout  ROM read data, valid one clock edge after rom_en/rom_addr are sampled
//   data_out  registered word to the loader (DATA_W bits)
//   ROM_RDY   one-cycle data_out valid strobe per word
//   busy      burst in progress
//   done      one-cycle pulse after the last word of a burst
interface pb_rom_feeder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 2
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [DATA_W-1:0] data_out;
    logic              ROM_RDY;
    logic              busy;
    logic              done;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_dout,
        output data_out,
        output ROM_RDY,
        output busy,
        output done
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_dout,
        input  data_out,
        input  ROM_RDY,
        input  busy,
        input  done
    );
endinterface

// File: rtl/pb_rom_feeder.sv
// Push-button ROM feeder. Debounces PB_in and, on each clean debounced press, reads
// NUM_WORDS words from a synchronous ROM and presents each one on data_out with a
// one-cycle ROM_RDY strobe for the downstream RAM loader.
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   PB_in  raw active-high push button, asynchronous to clk
//   bus    pb_rom_feeder_if master: ROM read port (rom_en/rom_addr/rom_dout) and
//          loader side (data_out/ROM_RDY) plus busy/done status
module pb_rom_feeder #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned NUM_WORDS    = 4,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PB_in,
    pb_rom_feeder_if.master   bus
);

    localparam int unsigned             CntW     = $clog2(DEBOUNCE_CYC);
    localparam logic [CntW-1:0]         LastCnt  = CntW'(DEBOUNCE_CYC - 1);
    localparam logic [ADDR_W-1:0]       LastAddr = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // ---------------------------------------------------------------------------------
    // Input path: synchronizer, debounce, rising-edge detect
    // ---------------------------------------------------------------------------------
    logic            sync1_q;
    logic            pb_s_q;
    logic            pb_db_q, pb_db_d;
    logic            pb_db_prev_q;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            pb_s_q       <= 1'b0;
            pb_db_q      <= 1'b0;
            pb_db_prev_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= PB_in;
            pb_s_q       <= sync1_q;
            pb_db_q      <= pb_db_d;
            pb_db_prev_q <= pb_db_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // The level only flips after DEBOUNCE_CYC consecutive disagreeing samples; any
    // agreement in between restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        pb_db_d  = pb_db_q;
        if (pb_s_q == pb_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == LastCnt) begin
            pb_db_d  = ~pb_db_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign start = pb_db_q & ~pb_db_prev_q;

    // ---------------------------------------------------------------------------------
    // Burst FSM
    // ---------------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_d1_q;
    logic              rdy_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start pulses arriving in any other state are dropped, not queued
                if (start) begin
                    state_d    = StIssue;
                    rom_en_d   = 1'b1;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                end
            end
            StIssue: begin
                // Compare against the last address so NUM_WORDS < 2**ADDR_W works
                if (rom_addr_q == LastAddr) begin
                    rom_en_d = 1'b0;
                    state_d  = StDrain;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end
            end
            StDrain: begin
                // Leave once en_d1 and ROM_RDY will both be low after this edge, so done
                // lands in the cycle right after the last ROM_RDY.
                if (!rom_en_q && !en_d1_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Read pipeline: ROM data is valid one edge after the request, then registered.
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d1_q <= 1'b0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            en_d1_q <= rom_en_q;
            rdy_q   <= en_d1_q;
            if (en_d1_q) begin
                data_q <= bus.rom_dout;
            end
        end
    end

    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.data_out = data_q;
    assign bus.ROM_RDY  = rdy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
